spwm_gate_gen: RTL

//  Three-phase sinusoidal PWM gate generator, directly downstream of the 120-degree comparison-value ROM.

---
 rtl/spwm_gate_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/spwm_gate_gen.sv
// Three-phase centre-aligned sinusoidal PWM with shadowed compare/dead-time registers,
// a shared up/down carrier and per-phase complementary gate drives with dead-time insertion.
module spwm_gate_gen #(
  parameter int                     CMP_WIDTH   = 16,
  parameter logic [CMP_WIDTH-1:0]   CARRIER_TOP = 16'hFFFF,
  parameter int                     DT_WIDTH    = 8,
  parameter logic [DT_WIDTH-1:0]    DT_RESET    = 8'd16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CMP_WIDTH-1:0] cmp_a,
  input  logic [CMP_WIDTH-1:0] cmp_b,
  input  logic [CMP_WIDTH-1:0] cmp_c,
  input  logic [DT_WIDTH-1:0]  dt,
  output logic                 sample,
  output logic [CMP_WIDTH-1:0] carrier,
  output logic                 hi_a,
  output logic                 lo_a,
  output logic                 hi_b,
  output logic                 lo_b,
  output logic                 hi_c,
  output logic                 lo_c
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  dir_t                 dir, dir_nxt;
  logic [CMP_WIDTH-1:0] carrier_nxt;
  logic                 valley;

  logic [CMP_WIDTH-1:0] cmp_in  [3];
  logic [CMP_WIDTH-1:0] act_cmp [3];
  logic [DT_WIDTH-1:0]  act_dt;
  logic [DT_WIDTH-1:0]  cnt     [3];
  logic [2:0]           raw, rprev, hi, lo;

  assign cmp_in[0] = cmp_a;
  assign cmp_in[1] = cmp_b;
  assign cmp_in[2] = cmp_c;

  assign valley = en && (carrier == '0);
  // Qualified by rst_n so the strobe drops together with the asynchronous reset.
  assign sample = rst_n & valley;

  always_comb begin
    carrier_nxt = carrier;
    dir_nxt     = dir;
    if (!en) begin
      carrier_nxt = '0;
      dir_nxt     = DIR_UP;
    end else if (dir == DIR_UP) begin
      carrier_nxt = carrier + CMP_WIDTH'(1);
      if (carrier_nxt == CARRIER_TOP) dir_nxt = DIR_DOWN;
    end else begin
      carrier_nxt = carrier - CMP_WIDTH'(1);
      if (carrier_nxt == '0) dir_nxt = DIR_UP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carrier <= '0;
      dir     <= DIR_UP;
    end else begin
      carrier <= carrier_nxt;
      dir     <= dir_nxt;
    end
  end

  always_comb begin
    raw = '0;
    for (int unsigned i = 0; i < 3; i++) raw[i] = act_cmp[i] > carrier;
  end

  // rprev doubles as the dead-time target: it always holds the side to assert once cnt expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        act_cmp[i] <= '0;
        cnt[i]     <= DT_RESET;
      end
      act_dt <= DT_RESET;
      rprev  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (valley) begin
        act_cmp <= cmp_in;
        act_dt  <= dt;
      end
      for (int unsigned i = 0; i < 3; i++) begin
        if (!en) begin
          rprev[i] <= raw[i];
          cnt[i]   <= act_dt;
          hi[i]    <= 1'b0;
          lo[i]    <= 1'b0;
        end else if (raw[i] != rprev[i]) begin
          rprev[i] <= raw[i];
          if (act_dt == '0) begin
            cnt[i] <= '0;
            hi[i]  <= raw[i];
            lo[i]  <= ~raw[i];
          end else begin
            cnt[i] <= act_dt;
            hi[i]  <= 1'b0;
            lo[i]  <= 1'b0;
          end
        end else if (cnt[i] > DT_WIDTH'(1)) begin
          cnt[i] <= cnt[i] - DT_WIDTH'(1);
          hi[i]  <= 1'b0;
          lo[i]  <= 1'b0;
        end else begin
          cnt[i] <= '0;
          hi[i]  <= rprev[i];
          lo[i]  <= ~rprev[i];
        end
      end
    end
  end

  assign hi_a = hi[0];
  assign lo_a = lo[0];
  assign hi_b = hi[1];
  assign lo_b = lo[1];
  assign hi_c = hi[2];
  assign lo_c = lo[2];

endmodule
